// File: rtl/posit_pkg.sv
// Shared definitions for the posit arithmetic cluster: opcodes, default
// widths, tag/response records and the round-robin search helper.
package posit_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int POSIT_WIDTH = 8;
    localparam int ES          = 1;

    // Tag ids are sized for the largest supported requester count (8).
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [POSIT_WIDTH-1:0] result;
        logic                   zero;
    } rsp_t;

    // Round-robin search over up to MAX_REQ eligibility bits, starting at
    // ptr and wrapping at n. Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [3:0] res;
        int         j;
        res = '0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if ((i < n) && elig[j[2:0]]) res = {1'b1, j[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/posit_rsp_fifo.sv
// Show-ahead response FIFO; head data reads as zero while empty.
module posit_rsp_fifo
    import posit_pkg::*;
#(
    parameter int WIDTH = POSIT_WIDTH + 1,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;

    // Storage, pointers and occupancy; push and pop may coincide at any fill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;

    // Credit accounting upstream must make a push into a full FIFO impossible.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
                     !(i_push && w_full && !w_pop));

endmodule

// File: rtl/posit_issue_arbiter.sv
// Round-robin issue arbiter in front of one non-stallable posit pipeline.
// Each requester holds rsp_depth credits covering in-flight ops plus queued
// results, so a retiring result always finds room in its FIFO. The posit
// exponent size lives in posit_pkg only; nothing here depends on it.
module posit_issue_arbiter
    import posit_pkg::*;
#(
    parameter int posit_width = POSIT_WIDTH,
    parameter int num_req     = 2,
    parameter int latency     = 4,
    parameter int rsp_depth   = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [num_req-1:0]             i_req_valid,
    output logic [num_req-1:0]             o_req_ready,
    input  logic [2*num_req-1:0]           i_req_opcode,
    input  logic [posit_width*num_req-1:0] i_req_a,
    input  logic [posit_width*num_req-1:0] i_req_b,
    output logic [num_req-1:0]             o_rsp_valid,
    input  logic [num_req-1:0]             i_rsp_ready,
    output logic [posit_width*num_req-1:0] o_rsp_result,
    output logic [num_req-1:0]             o_rsp_zero,
    output logic                           o_pu_start,
    output logic [1:0]                     o_pu_opcode,
    output logic [posit_width-1:0]         o_pu_a,
    output logic [posit_width-1:0]         o_pu_b,
    input  logic                           i_pu_done,
    input  logic                           i_pu_zero,
    input  logic [posit_width-1:0]         i_pu_result,
    output logic                           o_seq_error
);

    localparam int CNT_W = $clog2(rsp_depth) + 1;

    logic                 r_live;
    logic [2:0]           r_ptr;
    logic [CNT_W-1:0]     r_outst [num_req];
    tag_t                 r_tag   [0:latency];
    logic                 r_seq_err;

    logic [MAX_REQ-1:0]   w_elig;
    logic [3:0]           w_pick;
    logic                 w_issue;
    logic [2:0]           w_gidx;
    logic                 w_ret;
    logic [num_req-1:0]   w_push;
    logic [num_req-1:0]   w_pop;
    logic [posit_width:0] w_head  [num_req];
    logic [CNT_W-1:0]     w_count [num_req];

    // Holds grants off until the first edge after reset so req_ready reads 0 in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    // Eligibility: valid request with a free credit.
    always_comb begin
        w_elig = '0;
        for (int r = 0; r < num_req; r++)
            w_elig[r] = i_req_valid[r] && (r_outst[r] < CNT_W'(rsp_depth));
    end

    assign w_pick  = rr_pick(w_elig, r_ptr, num_req);
    assign w_issue = w_pick[3] && r_live;
    assign w_gidx  = w_pick[2:0];

    // One-hot grant and operand mux toward the posit pipeline.
    always_comb begin
        o_req_ready = '0;
        o_pu_opcode = '0;
        o_pu_a      = '0;
        o_pu_b      = '0;
        for (int r = 0; r < num_req; r++) begin
            o_req_ready[r] = w_issue && (w_gidx == 3'(r));
            if (o_req_ready[r]) begin
                o_pu_opcode = i_req_opcode[2*r +: 2];
                o_pu_a      = i_req_a[posit_width*r +: posit_width];
                o_pu_b      = i_req_b[posit_width*r +: posit_width];
            end
        end
    end

    assign o_pu_start = w_issue;

    // Round-robin pointer moves past the winner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_ptr <= '0;
        else if (w_issue) r_ptr <= (w_gidx == 3'(num_req - 1)) ? 3'd0 : w_gidx + 3'd1;
    end

    // Tag pipe: entry 0 captures the issuing edge, the last entry lines up
    // with the cycle in which pu_done/pu_result belong to that op.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= latency; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= '{valid: w_issue, id: w_gidx};
            for (int i = 1; i <= latency; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_ret = r_tag[latency].valid;

    // Sticky flag for any disagreement between pu_done and the expected tag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_seq_err <= 1'b0;
        else          r_seq_err <= r_seq_err | (i_pu_done != w_ret);
    end

    assign o_seq_error = r_seq_err;

    // Credits: taken on issue, returned on pop; retire only moves the op into the FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < num_req; r++) r_outst[r] <= '0;
        end else begin
            for (int r = 0; r < num_req; r++) begin
                case ({o_req_ready[r], w_pop[r]})
                    2'b10:   r_outst[r] <= r_outst[r] + CNT_W'(1);
                    2'b01:   r_outst[r] <= r_outst[r] - CNT_W'(1);
                    default: r_outst[r] <= r_outst[r];
                endcase
            end
        end
    end

    for (genvar g = 0; g < num_req; g++) begin : g_rsp
        assign w_push[g] = w_ret && (r_tag[latency].id == TAG_ID_W'(g));
        assign w_pop[g]  = o_rsp_valid[g] && i_rsp_ready[g];

        posit_rsp_fifo #(
            .WIDTH (posit_width + 1),
            .DEPTH (rsp_depth)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_push  (w_push[g]),
            .i_data  ({i_pu_result, i_pu_zero}),
            .i_pop   (w_pop[g]),
            .o_valid (o_rsp_valid[g]),
            .o_data  (w_head[g]),
            .o_count (w_count[g])
        );

        assign o_rsp_result[posit_width*g +: posit_width] = w_head[g][posit_width:1];
        assign o_rsp_zero[g] = w_head[g][0];

        // Queued results are a subset of the credits held by this requester.
        assert property (@(posedge i_clk) disable iff (!i_rst_n)
                         r_outst[g] >= w_count[g]);
    end

endmodule

// File: doc/posit_issue_arbiter.md
Name: posit_issue_arbiter

Overview:
- Shares one pipelined posit_top arithmetic unit among num_req independent requesters.
- Arbitrates round-robin, issues at most one operation per cycle and tracks each in-flight operation with a requester tag.
- Routes each result back to a per-requester response FIFO.
- Uses credit-based flow control, because the posit pipeline cannot stall and no result may ever be dropped.

Parameters:
- posit_width, 8, posit word width
- es, 1, posit exponent size; passed through to the shared package only
- num_req, 2, number of requesters (2..8)
- latency, 4, issue-to-result pipeline depth of posit_top
- rsp_depth, 4, entries per response FIFO (power of 2, at least 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  num_req  per-requester request valid
- req_ready  out  num_req  per-requester grant; an op is accepted when valid and ready are both high at a rising edge
- req_opcode  in  2*num_req  packed opcodes; requester r occupies bits [2r+1:2r]
- req_a  in  posit_width*num_req  packed operand A
- req_b  in  posit_width*num_req  packed operand B
- rsp_valid  out  num_req  response FIFO not empty
- rsp_ready  in  num_req  pop the response FIFO head
- rsp_result  out  posit_width*num_req  head result of each FIFO
- rsp_zero  out  num_req  head zero flag of each FIFO
- pu_start  out  1  start pulse to posit_top
- pu_opcode  out  2  opcode to posit_top
- pu_a  out  posit_width  operand A to posit_top
- pu_b  out  posit_width  operand B to posit_top
- pu_done  in  1  done from posit_top
- pu_zero  in  1  zero from posit_top
- pu_result  in  posit_width  result from posit_top
- seq_error  out  1  sticky pu_done/tag mismatch flag

Behaviour:
- Reset (reset low, asynchronous) clears all of the following:
  - outputs: req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, pu_start=0, pu_opcode=0, pu_a=0, pu_b=0, seq_error=0
  - state: tag pipe, outstanding counters and FIFOs; round-robin pointer set to 0
  - Reset mid-operation discards all in-flight results.
- Eligibility: requester r is eligible when req_valid[r]=1 and outstanding[r] < rsp_depth.
  - outstanding[r] = in-flight tags for r + FIFO occupancy of r.
- Grant:
  - Combinational round-robin, starting the search at pointer ptr; at most one req_ready bit is high.
  - req_ready is never high for an ineligible requester.
  - Grant does not depend on rsp_ready in the same cycle. This is conservative; a pop frees the credit the following cycle.
- Issue (combinational, same cycle as the grant):
  - pu_start = |req_ready.
  - pu_opcode/pu_a/pu_b are muxed from the granted requester; they are 0 when idle.
  - posit_top samples them at the rising edge.
- Pointer: after a grant to r, ptr becomes (r+1) mod num_req; it is unchanged when idle.
- Tag pipe:
  - latency stages of {valid, id}. The issuing edge loads stage 0; each later edge shifts.
  - Last-stage valid means pu_result/pu_zero are valid in this cycle, i.e. the cycle after the latency-th edge after issue.
  - The next edge pushes {pu_result, pu_zero} into FIFO[id].
- Throughput: back-to-back issue every cycle is supported; with one requester it is limited only by rsp_depth credits.
- Counters:
  - outstanding[r] +1 on issue to r; -1 on pop of FIFO r.
  - Issue and pop in the same cycle leave it unchanged.
  - Retire (tag to FIFO) does not change outstanding.
- FIFO:
  - Show-ahead: rsp_valid[r] = not empty; popped on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are allowed when full or empty (push-to-empty is visible the next cycle).
  - Overflow cannot occur by construction; overflow is an assertion failure.
- seq_error: set at any edge where pu_done differs from the last-stage tag valid; cleared only by reset.
- Order: results of a single requester return in issue order.

Decomposition:
- Shared package posit_pkg:
  - opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11)
  - posit_width/es defaults
  - typedef for a tag struct {valid, id[$clog2(num_req)]}
  - typedef for a response struct {result, zero}
- One sub-module: posit_rsp_fifo (show-ahead, parameterised width/depth, count output), instantiated num_req times.
- The bench connects a real posit_top instance to the pu_* ports.

Test Plan:
- Single mul: req0 OP_MUL a=0x48 (1.5) b=0x50 (2.0) -> pu_start one cycle; rsp_valid[0] 6 cycles after the accept edge, rsp_result[0]=0x58, rsp_zero[0]=0.
- Zero: req1 OP_MUL a=0x00 b=0x50 -> rsp_result[1]=0x00, rsp_zero[1]=1, seq_error stays 0.
- Contention: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; pu_start high every cycle; each requester's results arrive in order.
- Backpressure: req0 streaming, rsp_ready[0]=0 -> exactly 4 accepts (rsp_depth), then req_ready[0]=0. Raising rsp_ready[0] frees one credit per pop, and the 5th op is accepted the cycle after the first pop.
- Reset mid-flight: 3 ops issued, reset low for 1 cycle -> all outputs 0, no rsp_valid afterwards, a new op then completes normally.
- Done mismatch: force pu_done=1 while the tag pipe is empty -> seq_error=1, sticky until reset.
